rtc_edit_ctrl: RTL and testbench
================================

Name: rtc_edit_ctrl

Overview:
Configuration sequencer for the RTC display. It takes debounced button pulses and walks the user through editing the time, date or timer, one two-digit BCD field at a time. It drives the field values, edit mode, field cursor and blink gate into the pixel generator. On exit from edit it commits the three edited fields to the RTC bus master over a req/ack write handshake.

Parameters:
BLINK_FRAMES, 30, frame_tick pulses per blink half-period (1..255)
HORA_BASE, 8'h21, RTC address of seconds; minutes at +1, hours at +2
FECHA_BASE, 8'h24, RTC address of year; month at +1, day at +2
TIMER_BASE, 8'h41, RTC address of timer seconds; minutes at +1, hours at +2
ACK_TIMEOUT, 1023, cycles to wait for wr_ack (used only with the optional feature)

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
btn_mode  in  1  one-cycle pulse: advance the edit mode
btn_up  in  1  one-cycle pulse: increment the selected field
btn_down  in  1  one-cycle pulse: decrement the selected field
btn_left  in  1  one-cycle pulse: cursor left
btn_right  in  1  one-cycle pulse: cursor right
frame_tick  in  1  one-cycle pulse per VGA frame
cur_f0, cur_f1, cur_f2  in  8 each  live BCD values of the leftmost, middle and rightmost field (HH/MM/SS, DD/MO/YY, or timer HH/MM/SS, selected by edit_mode target)
wr_ack  in  1  RTC master accepted the write
edit_mode  out  2  0 normal, 1 hora, 2 fecha, 3 timer
field_sel  out  2  0 left, 1 middle, 2 right
blink_on  out  1  1 = draw the selected field
f0, f1, f2  out  8 each  BCD edit buffer
wr_req  out  1  write request
wr_addr  out  8  write address
wr_data  out  8  write data
busy  out  1  high during commit
wr_err  out  1  sticky timeout flag (optional feature)

Behaviour:
- All outputs are registered. Reset values: edit_mode=0, field_sel=0, blink_on=1, f0/f1/f2=8'h00, wr_req=0, wr_addr=0, wr_data=0, busy=0, wr_err=0. State resets to IDLE.
- States:
  - IDLE: edit_mode=0.
  - EDIT: edit_mode=1/2/3.
  - COMMIT: busy=1.
- Button priority: only one button is acted on per cycle, in the order mode > up > down > right > left. All buttons are ignored in COMMIT.
- IDLE + btn_mode: go to EDIT with edit_mode=1. Capture cur_f0..2 into f0..2 on the same edge. field_sel=0, blink counter cleared, blink_on=1.
- EDIT + btn_mode: go to COMMIT for the current edit_mode, with write index k=0.
- COMMIT completion: after k=2 is acknowledged, return to IDLE if the committed mode was 3. Otherwise go to EDIT with edit_mode+1, recapture cur_* and set field_sel=0.
- btn_right: field_sel 0->1->2->0. btn_left: 0->2->1->0.
- btn_up / btn_down: BCD ±1 on the selected field, wrapping at the limits below:
  - hora/timer: f0 00..23, f1 and f2 00..59.
  - fecha: f0 01..31, f1 01..12, f2 00..99.
  - Wrap examples: up from max gives min; down from min gives max.
  - Values are always legal BCD.
- Any cursor or value change clears the blink counter and sets blink_on=1.
- Blink in EDIT: count frame_tick pulses. At BLINK_FRAMES, toggle blink_on and clear the counter. Outside EDIT, blink_on=1.
- COMMIT writes three times, in order k=0,1,2:
  - wr_addr = BASE+k.
  - wr_data = f2, f1, f0 respectively.
- Write handshake:
  - wr_req rises the cycle after COMMIT is entered.
  - wr_addr and wr_data are held stable while wr_req=1.
  - A write completes on an edge where wr_req & wr_ack. wr_req drops for exactly one cycle, then the next write presents.
  - wr_ack while wr_req=0 is ignored.
- Reset mid-COMMIT: on the next edge wr_req=0, busy=0 and state=IDLE. No further writes are issued.

Optional Feature:
RTC_WR_TIMEOUT_EN
- Defined: a cycle counter runs while wr_req=1 and no ack has arrived. At ACK_TIMEOUT it aborts the commit: wr_req=0, wr_err=1 (sticky until RESET or the next btn_mode), and the state goes to IDLE.
- Undefined: the block waits for wr_ack indefinitely, and wr_err is tied to 0.

Test Plan:
- Reset: RESET held for 2 cycles -> all outputs at the reset values, edit_mode=0, blink_on=1.
- Enter and edit hora: cur=23/59/58, btn_mode, btn_up -> f0 wraps 23 to 00. btn_right, btn_down ×60 -> f1 returns to 59.
- Fecha limits: in edit_mode=2 with f1=12, btn_up -> 01. btn_left from field_sel 0 -> 2. f2=00 with btn_down -> 99.
- Commit handshake: hora with f=12/34/56, btn_mode, wr_ack delayed 3 cycles each -> writes (21,56), (22,34), (23,12) in order, each held until acked, then edit_mode=2.
- Blink: BLINK_FRAMES=2, 5 frame_ticks in EDIT with no buttons -> blink_on sequence 1,1,0,0,1. btn_up restores 1 immediately.
- Reset during COMMIT after the first ack -> wr_req=0 next cycle, no address 22 write. With RTC_WR_TIMEOUT_EN and no ack -> wr_err=1 after 1023 cycles, state IDLE.

Source files
------------

// File: rtl/rtc_edit_ctrl.sv
// Edit/commit sequencer for RTC time, date and timer fields (BCD, two digits per field).
// Optional macro RTC_WR_TIMEOUT_EN: abort a commit when wr_ack does not arrive in time.

module rtc_edit_ctrl #(
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [7:0]  HORA_BASE    = 8'h21,
    parameter logic [7:0]  FECHA_BASE   = 8'h24,
    parameter logic [7:0]  TIMER_BASE   = 8'h41,
    parameter int unsigned ACK_TIMEOUT  = 1023
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       frame_tick,
    input  logic [7:0] cur_f0,
    input  logic [7:0] cur_f1,
    input  logic [7:0] cur_f2,
    input  logic       wr_ack,
    output logic [1:0] edit_mode,
    output logic [1:0] field_sel,
    output logic       blink_on,
    output logic [7:0] f0,
    output logic [7:0] f1,
    output logic [7:0] f2,
    output logic       wr_req,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       wr_err
);

    typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_t;

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES);

    state_t     state_q;
    logic [1:0] edit_mode_q, field_sel_q, k_q;
    logic       blink_on_q, wr_req_q, busy_q, wr_err_q;
    logic [7:0] blink_cnt_q, f0_q, f1_q, f2_q, wr_addr_q, wr_data_q;
`ifdef RTC_WR_TIMEOUT_EN
    localparam int unsigned    TO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    logic [TO_W-1:0] to_cnt_q;
`endif

    logic [7:0] fld_cur, fld_min, fld_max, fld_new_d, wr_base, wr_addr_d, wr_data_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        fld_cur = f0_q;
        fld_min = 8'h00;
        fld_max = 8'h59;
        wr_base = HORA_BASE;
        case (field_sel_q)
            2'd1:    fld_cur = f1_q;
            2'd2:    fld_cur = f2_q;
            default: ;
        endcase
        if (edit_mode_q == 2'd2) begin
            case (field_sel_q)
                2'd0:    begin fld_min = 8'h01; fld_max = 8'h31; end
                2'd1:    begin fld_min = 8'h01; fld_max = 8'h12; end
                default: fld_max = 8'h99;
            endcase
        end else if (field_sel_q == 2'd0) begin
            fld_max = 8'h23;
        end
        case (edit_mode_q)
            2'd2:    wr_base = FECHA_BASE;
            2'd3:    wr_base = TIMER_BASE;
            default: ;
        endcase
        // BCD compares order like binary, so limits can be tested directly.
        if (btn_up)
            fld_new_d = (fld_cur >= fld_max) ? fld_min :
                        (fld_cur[3:0] == 4'h9) ? {fld_cur[7:4] + 4'h1, 4'h0} : fld_cur + 8'h01;
        else
            fld_new_d = (fld_cur <= fld_min) ? fld_max :
                        (fld_cur[3:0] == 4'h0) ? {fld_cur[7:4] - 4'h1, 4'h9} : fld_cur - 8'h01;
        wr_addr_d = wr_base + {6'd0, k_q};
        wr_data_d = (k_q == 2'd0) ? f2_q : (k_q == 2'd1) ? f1_q : f0_q;
    end

    // NOTE: all state below uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            edit_mode_q <= 2'd0;
            field_sel_q <= 2'd0;
            k_q         <= 2'd0;
            blink_on_q  <= 1'b1;
            blink_cnt_q <= 8'd0;
            f0_q        <= 8'h00;
            f1_q        <= 8'h00;
            f2_q        <= 8'h00;
            wr_req_q    <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
            busy_q      <= 1'b0;
            wr_err_q    <= 1'b0;
`ifdef RTC_WR_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    blink_on_q <= 1'b1;
                    if (btn_mode) begin
                        state_q     <= S_EDIT;
                        edit_mode_q <= 2'd1;
                        field_sel_q <= 2'd0;
                        blink_cnt_q <= 8'd0;
                        wr_err_q    <= 1'b0;
                        f0_q        <= cur_f0;
                        f1_q        <= cur_f1;
                        f2_q        <= cur_f2;
                    end
                end
                S_EDIT: begin
                    if (btn_mode) begin
                        state_q     <= S_COMMIT;
                        k_q         <= 2'd0;
                        busy_q      <= 1'b1;
                        wr_req_q    <= 1'b0;
                        wr_err_q    <= 1'b0;
                        blink_on_q  <= 1'b1;
                        blink_cnt_q <= 8'd0;
                    end else if (btn_up || btn_down || btn_right || btn_left) begin
                        blink_on_q  <= 1'b1;
                        blink_cnt_q <= 8'd0;
                        if (btn_up || btn_down) begin
                            case (field_sel_q)
                                2'd1:    f1_q <= fld_new_d;
                                2'd2:    f2_q <= fld_new_d;
                                default: f0_q <= fld_new_d;
                            endcase
                        end else if (btn_right) begin
                            field_sel_q <= (field_sel_q == 2'd2) ? 2'd0 : field_sel_q + 2'd1;
                        end else begin
                            field_sel_q <= (field_sel_q == 2'd0) ? 2'd2 : field_sel_q - 2'd1;
                        end
                    end else if (frame_tick) begin
                        if (blink_cnt_q + 8'd1 == BLINK_LAST) begin
                            blink_on_q  <= ~blink_on_q;
                            blink_cnt_q <= 8'd0;
                        end else begin
                            blink_cnt_q <= blink_cnt_q + 8'd1;
                        end
                    end
                end
                S_COMMIT: begin
                    if (!wr_req_q) begin
                        wr_req_q  <= 1'b1;
                        wr_addr_q <= wr_addr_d;
                        wr_data_q <= wr_data_d;
`ifdef RTC_WR_TIMEOUT_EN
                        to_cnt_q  <= '0;
`endif
                    end else if (wr_ack) begin
                        wr_req_q <= 1'b0;
                        if (k_q == 2'd2) begin
                            busy_q <= 1'b0;
                            if (edit_mode_q == 2'd3) begin
                                state_q     <= S_IDLE;
                                edit_mode_q <= 2'd0;
                                field_sel_q <= 2'd0;
                            end else begin
                                state_q     <= S_EDIT;
                                edit_mode_q <= edit_mode_q + 2'd1;
                                field_sel_q <= 2'd0;
                                blink_cnt_q <= 8'd0;
                                blink_on_q  <= 1'b1;
                                f0_q        <= cur_f0;
                                f1_q        <= cur_f1;
                                f2_q        <= cur_f2;
                            end
                        end else begin
                            k_q <= k_q + 2'd1;
                        end
`ifdef RTC_WR_TIMEOUT_EN
                    end else if (to_cnt_q == TO_LAST) begin
                        wr_req_q    <= 1'b0;
                        wr_err_q    <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                        edit_mode_q <= 2'd0;
                        field_sel_q <= 2'd0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign edit_mode = edit_mode_q;
    assign field_sel = field_sel_q;
    assign blink_on  = blink_on_q;
    assign f0        = f0_q;
    assign f1        = f1_q;
    assign f2        = f2_q;
    assign wr_req    = wr_req_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_rtc_edit_ctrl.sv
// Randomized bench for rtc_edit_ctrl against a field/limit-level reference model.
// Define RTC_WR_TIMEOUT_EN for both bench and RTL to exercise the ack timeout.

module tb_rtc_edit_ctrl;

    localparam int BF = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       btn_mode = 0, btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
    logic       frame_tick = 0, wr_ack = 0;
    logic [7:0] cur_f0 = 0, cur_f1 = 0, cur_f2 = 0;
    logic [1:0] edit_mode, field_sel;
    logic       blink_on, wr_req, busy, wr_err;
    logic [7:0] f0, f1, f2, wr_addr, wr_data;

    rtc_edit_ctrl #(.BLINK_FRAMES(BF)) dut (
        .CLK(CLK), .RESET(RESET),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right), .frame_tick(frame_tick),
        .cur_f0(cur_f0), .cur_f1(cur_f1), .cur_f2(cur_f2), .wr_ack(wr_ack),
        .edit_mode(edit_mode), .field_sel(field_sel), .blink_on(blink_on),
        .f0(f0), .f1(f1), .f2(f2), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .wr_err(wr_err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int         m_mode, m_sel, m_blink, m_bcnt;
    logic [7:0] m_f [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bcd2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] i2bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int lo_lim(input int mode, input int fld);
        return (mode == 2 && fld < 2) ? 1 : 0;
    endfunction

    function automatic int hi_lim(input int mode, input int fld);
        if (mode == 2) return (fld == 0) ? 31 : (fld == 1) ? 12 : 99;
        return (fld == 0) ? 23 : 59;
    endfunction

    function automatic logic [7:0] step(input int mode, input int fld, input logic [7:0] b, input int dir);
        int lo, span;
        lo   = lo_lim(mode, fld);
        span = hi_lim(mode, fld) - lo + 1;
        return i2bcd(((bcd2i(b) - lo + dir + span) % span) + lo);
    endfunction

    function automatic logic [7:0] rand_bcd(input int mode, input int fld);
        int lo;
        lo = lo_lim(mode, fld);
        return i2bcd(lo + int'($urandom_range(hi_lim(mode, fld) - lo)));
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // b = {mode, up, down, right, left}
    task automatic press(input logic [4:0] b);
        {btn_mode, btn_up, btn_down, btn_right, btn_left} = b;
        tick();
        {btn_mode, btn_up, btn_down, btn_right, btn_left} = 5'b0;
    endtask

    task automatic model_enter(input int mode);
        m_mode = mode; m_sel = 0; m_blink = 1; m_bcnt = 0;
        m_f[0] = cur_f0; m_f[1] = cur_f1; m_f[2] = cur_f2;
    endtask

    task automatic model_btn(input logic [3:0] b);  // {up, down, right, left}
        if (b[3] || b[2]) begin
            m_f[m_sel] = step(m_mode, m_sel, m_f[m_sel], b[3] ? 1 : -1);
            m_blink = 1; m_bcnt = 0;
        end else if (b[1] || b[0]) begin
            m_sel = b[1] ? (m_sel + 1) % 3 : (m_sel + 2) % 3;
            m_blink = 1; m_bcnt = 0;
        end
    endtask

    task automatic check_edit(input string tag);
        check({tag, ".mode"}, edit_mode, m_mode);
        check({tag, ".sel"}, field_sel, m_sel);
        check({tag, ".f0"}, f0, m_f[0]);
        check({tag, ".f1"}, f1, m_f[1]);
        check({tag, ".f2"}, f2, m_f[2]);
        check({tag, ".blink"}, blink_on, m_blink);
        check({tag, ".busy"}, busy, 0);
    endtask

    task automatic do_btn(input logic [3:0] b, input string tag);
        press({1'b0, b});
        model_btn(b);
        check_edit(tag);
    endtask

    task automatic do_frame(input string tag);
        frame_tick = 1'b1;
        check({tag, ".blink_pre"}, blink_on, m_blink);
        tick();
        frame_tick = 1'b0;
        m_bcnt++;
        if (m_bcnt == BF) begin m_blink ^= 1; m_bcnt = 0; end
        check({tag, ".blink_post"}, blink_on, m_blink);
    endtask

    task automatic random_edit(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3) == 0) do_frame(tag);
            else do_btn(4'($urandom_range(1, 15)), tag);
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!wr_req && n < 20) begin tick(); n++; end
        check({tag, ".req_rise"}, wr_req, 1);
    endtask

    // Commit the model's current fields; dly<0 means random ack latency.
    task automatic commit(input int dly, input logic [7:0] n0, n1, n2, input string tag);
        logic [7:0] base, exp_a, exp_d;
        int         d, next_mode;
        base = (m_mode == 2) ? 8'h24 : (m_mode == 3) ? 8'h41 : 8'h21;
        next_mode = (m_mode == 3) ? 0 : m_mode + 1;
        cur_f0 = n0; cur_f1 = n1; cur_f2 = n2;
        press(5'b10000);
        check({tag, ".busy_entry"}, busy, 1);
        check({tag, ".req_entry"}, wr_req, 0);
        check({tag, ".blink_entry"}, blink_on, 1);
        for (int k = 0; k < 3; k++) begin
            exp_a = base + 8'(k);
            exp_d = m_f[2 - k];
            wait_req(tag);
            check({tag, ".addr"}, wr_addr, exp_a);
            check({tag, ".data"}, wr_data, exp_d);
            d = (dly < 0) ? int'($urandom_range(4)) : dly;
            for (int i = 0; i < d; i++) begin
                tick();
                check({tag, ".hold_req"}, wr_req, 1);
                check({tag, ".hold_addr"}, wr_addr, exp_a);
                check({tag, ".hold_data"}, wr_data, exp_d);
            end
            wr_ack = 1'b1;
            tick();
            wr_ack = 1'b0;
            check({tag, ".req_drop"}, wr_req, 0);
            if (k < 2) begin
                wr_ack = 1'($urandom_range(1));  // ack during the gap must be ignored
                tick();
                wr_ack = 1'b0;
                check({tag, ".req_gap1"}, wr_req, 1);
            end
        end
        check({tag, ".busy_done"}, busy, 0);
        check({tag, ".mode_done"}, edit_mode, next_mode);
        check({tag, ".err_done"}, wr_err, 0);
        if (next_mode != 0) begin
            model_enter(next_mode);
            check_edit({tag, ".recap"});
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tick(); tick();
        RESET = 1'b0;
        check("rst.mode", edit_mode, 0);
        check("rst.sel", field_sel, 0);
        check("rst.blink", blink_on, 1);
        check("rst.f", {f0, f1, f2}, 0);
        check("rst.req", wr_req, 0);
        check("rst.addr", wr_addr, 0);
        check("rst.data", wr_data, 0);
        check("rst.busy", busy, 0);
        check("rst.err", wr_err, 0);

        // Hora: mode wins over a simultaneous up press.
        cur_f0 = 8'h23; cur_f1 = 8'h59; cur_f2 = 8'h58;
        press(5'b11000);
        model_enter(1);
        check_edit("hora.enter");
        do_btn(4'b1000, "hora.up_wrap");
        check("hora.f0_wrap", f0, 8'h00);
        do_btn(4'b0010, "hora.right");
        for (int i = 0; i < 60; i++) do_btn(4'b0100, "hora.down");
        check("hora.f1_back", f1, 8'h59);
        random_edit(40, "hora.rand");

        // Into fecha with directed limit checks.
        commit(-1, 8'h31, 8'h12, 8'h00, "c_hora");
        do_btn(4'b0001, "fecha.left");
        check("fecha.left_sel", field_sel, 2);
        do_btn(4'b0100, "fecha.f2_down");
        check("fecha.f2_wrap", f2, 8'h99);
        do_btn(4'b0010, "fecha.right0");
        do_btn(4'b1000, "fecha.f0_up");
        check("fecha.f0_wrap", f0, 8'h01);
        do_btn(4'b0010, "fecha.right1");
        do_btn(4'b1000, "fecha.f1_up");
        check("fecha.f1_wrap", f1, 8'h01);
        random_edit(40, "fecha.rand");

        commit(-1, rand_bcd(3, 0), rand_bcd(3, 1), rand_bcd(3, 2), "c_fecha");
        random_edit(40, "timer.rand");
        commit(-1, 8'h00, 8'h00, 8'h00, "c_timer");
        check("idle.mode", edit_mode, 0);

        // Fixed-latency commit of 12/34/56, then blink in fecha.
        cur_f0 = 8'h12; cur_f1 = 8'h34; cur_f2 = 8'h56;
        press(5'b10000);
        model_enter(1);
        check_edit("hora2.enter");
        commit(3, rand_bcd(2, 0), rand_bcd(2, 1), rand_bcd(2, 2), "c_hora2");
        for (int i = 0; i < 6; i++) do_frame("blink");
        check("blink.after6", blink_on, 0);
        do_btn(4'b1000, "blink.up");
        check("blink.restored", blink_on, 1);

        // Reset in the gap after the first acknowledged write.
        RESET = 1'b1; tick(); RESET = 1'b0;
        cur_f0 = 8'h01; cur_f1 = 8'h02; cur_f2 = 8'h03;
        press(5'b10000);
        press(5'b10000);
        wait_req("rst_mid");
        check("rst_mid.addr0", wr_addr, 8'h21);
        wr_ack = 1'b1; tick(); wr_ack = 1'b0;
        RESET = 1'b1; tick(); RESET = 1'b0;
        check("rst_mid.req", wr_req, 0);
        check("rst_mid.busy", busy, 0);
        check("rst_mid.mode", edit_mode, 0);
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                wr_ack = 1'($urandom_range(1));
                tick();
                if (wr_req) seen++;
            end
            wr_ack = 1'b0;
            check("rst_mid.no_more_writes", seen, 0);
        end

`ifdef RTC_WR_TIMEOUT_EN
        begin
            int hi = 0;
            press(5'b10000);
            press(5'b10000);
            for (int i = 0; i < 1200; i++) begin
                tick();
                if (wr_req) hi++;
                else if (hi > 0) break;
            end
            check("to.req_cycles", hi, 1023);
            check("to.err", wr_err, 1);
            check("to.mode", edit_mode, 0);
            check("to.busy", busy, 0);
            press(5'b10000);
            check("to.err_clear", wr_err, 0);
            check("to.reenter", edit_mode, 1);
        end
`else
        check("no_to.err", wr_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
